if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage ARM pipeline. Holds the PC, drives the
//   byte-addressed big-endian instruction memory, computes PC+4, and applies branch
//   redirects from EXE. Owns the IF/ID pipeline register feeding ID, with freeze
//   (hazard stall) and flush. Memory read is combinational; the word is valid in the same cycle.
// PARAMETERS
//   INSTR_W   32            instruction / data width (`INSTRUCTION_LEN)
//   ADDR_W    32            PC / byte-address width
//   RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous, active-high reset
//   freeze        in   1        hazard stall: hold PC and IF/ID
//   flush         in   1        squash IF/ID contents (insert bubble)
//   branch_taken  in   1        redirect PC to branch_addr (from EXE)
//   branch_addr   in   ADDR_W   branch target, byte address
//   imem_addr     out  ADDR_W   instruction memory byte address (= pc)
//   imem_read     out  1        instruction memory read enable
//   imem_rdata    in   INSTR_W  {data[a],data[a+1],data[a+2],data[a+3]}
//   if_id_pc      out  ADDR_W   PC+4 of the captured instruction
//   if_id_instr   out  INSTR_W  captured instruction
//   if_id_valid   out  1        IF/ID holds a real instruction (0 = bubble)
//   fetch_count   out  32       retired-fetch counter (performance)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): pc<=RESET_PC; if_id_pc<=0; if_id_instr<=0;
//     if_id_valid<=0; fetch_count<=0. rst overrides every other input.
//   - imem_addr = pc (combinational); imem_read = !rst.
//   - pc_plus4 = pc + 4, computed modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
//   - Next PC, priority order:
//       1 branch_taken    -> pc <= {branch_addr[ADDR_W-1:2],2'b00} (also during freeze)
//       2 freeze          -> pc holds
//       3 otherwise       -> pc <= pc_plus4
//   - IF/ID register, priority order:
//       1 flush | branch_taken -> if_id_instr<=0, if_id_pc<=0, if_id_valid<=0
//       2 freeze               -> all IF/ID fields hold
//       3 otherwise            -> if_id_instr<=imem_rdata, if_id_pc<=pc_plus4,
//                                 if_id_valid<=1
//   - Latency: the instruction at address A is presented on if_id_* one cycle after
//     pc==A with no freeze. Redirect costs one bubble in IF/ID: the branch-cycle fetch
//     is dropped, and the target is captured in the following cycle.
//   - fetch_count increments by 1 on each posedge that loads case 3. It saturates
//     at 32'hFFFF_FFFF. Flush, freeze and redirect cycles do not count.
//   - Reset mid-stream discards the in-flight IF/ID contents. The first post-reset
//     fetch is from RESET_PC on the cycle after rst drops.
//   - All outputs are registered except imem_addr and imem_read. There are no latches;
//     a single clocked always block holds pc, IF/ID and the counter.
// TESTING
//   1 Reset then free-run 3 cycles -> imem_addr 0,4,8; the 2nd capture gives
//     if_id_instr=32'hE3A00014 and if_id_pc=8; if_id_valid=1; fetch_count=3.
//   2 freeze=1 for 2 cycles with pc=12 -> imem_addr stays 12; if_id_* unchanged;
//     fetch_count unchanged; on release pc advances to 16.
//   3 branch_taken=1, branch_addr=32'h0000_0093 at pc=152 -> next pc=0x90;
//     if_id_valid=0 for one cycle; the next capture has if_id_pc=0x94.
//   4 branch_taken=1 and freeze=1 in the same cycle -> pc loads the target and IF/ID
//     is bubbled. flush=1 alone -> pc advances by 4 and if_id_valid=0.
//   5 Force pc to 32'hFFFF_FFFC, run 1 cycle -> pc=0 and if_id_pc=0.
//   6 Assert rst while if_id_valid=1 and fetch_count=7 -> next edge gives pc=RESET_PC,
//     if_id_valid=0 and fetch_count=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4, branch redirect, and the IF/ID
// pipeline register with freeze/flush, plus a saturating retired-fetch counter.
module if_stage #(
    parameter int unsigned           INSTR_W  = 32,
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_read,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [31:0]        fetch_count
);

    localparam int unsigned CNT_W = 32;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic               squash;
    logic               load;

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign imem_addr = pc_q;
    assign imem_read = !rst;

    // A redirect squashes the instruction fetched in the branch cycle.
    assign squash = flush || branch_taken;
    assign load   = !squash && !freeze;

    // Next-state for PC, IF/ID and counter.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;

        if (branch_taken) begin
            pc_d = {branch_addr[ADDR_W-1:2], 2'b00};
        end else if (!freeze) begin
            pc_d = pc_plus4;
        end

        if (squash) begin
            if_id_pc_d    = '0;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
        end else if (!freeze) begin
            if_id_pc_d    = pc_plus4;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
        end

        if (load && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a big-endian byte memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
    endfunction

    assign imem_rdata = word_at(imem_addr);

    typedef struct {
        logic        frz;
        logic        fls;
        logic        br;
        logic [31:0] baddr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] idpc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic frz, input logic fls, input logic br,
                                input logic [31:0] baddr, input logic [31:0] pc,
                                input logic valid, input logic [31:0] idpc,
                                input logic [31:0] instr, input logic [31:0] cnt);
        vec_t v;
        v.frz = frz; v.fls = fls; v.br = br; v.baddr = baddr;
        v.pc = pc; v.valid = valid; v.idpc = idpc; v.instr = instr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic frz, input logic fls,
                         input logic br, input logic [31:0] baddr);
        rst = r; freeze = frz; flush = fls; branch_taken = br; branch_addr = baddr;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic valid,
                             input logic [31:0] idpc, input logic [31:0] instr,
                             input logic [31:0] cnt);
        chk({tag, ".pc"},    imem_addr, pc);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
        chk({tag, ".idpc"},  if_id_pc, idpc);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".cnt"},   fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37) + 11);
        mem[4] = 8'hE3; mem[5] = 8'hA0; mem[6] = 8'h00; mem[7] = 8'h14;

        //              frz fls br baddr         pc            v  idpc          instr                 cnt
        tbl[0]  = mk(0, 0, 0, 32'h0,         32'h4,        1, 32'h4,        word_at(32'h0),       1);
        tbl[1]  = mk(0, 0, 0, 32'h0,         32'h8,        1, 32'h8,        32'hE3A00014,         2);
        tbl[2]  = mk(0, 0, 0, 32'h0,         32'hC,        1, 32'hC,        word_at(32'h8),       3);
        tbl[3]  = mk(1, 0, 0, 32'h0,         32'hC,        1, 32'hC,        word_at(32'h8),       3);
        tbl[4]  = mk(1, 0, 0, 32'h0,         32'hC,        1, 32'hC,        word_at(32'h8),       3);
        tbl[5]  = mk(0, 0, 0, 32'h0,         32'h10,       1, 32'h10,       word_at(32'hC),       4);
        tbl[6]  = mk(0, 0, 1, 32'h94,        32'h94,       0, 32'h0,        32'h0,                4);
        tbl[7]  = mk(0, 0, 0, 32'h0,         32'h98,       1, 32'h98,       word_at(32'h94),      5);
        tbl[8]  = mk(0, 0, 1, 32'h93,        32'h90,       0, 32'h0,        32'h0,                5);
        tbl[9]  = mk(0, 0, 0, 32'h0,         32'h94,       1, 32'h94,       word_at(32'h90),      6);
        tbl[10] = mk(1, 0, 1, 32'h41,        32'h40,       0, 32'h0,        32'h0,                6);
        tbl[11] = mk(0, 0, 0, 32'h0,         32'h44,       1, 32'h44,       word_at(32'h40),      7);
        tbl[12] = mk(0, 1, 0, 32'h0,         32'h48,       0, 32'h0,        32'h0,                7);
        tbl[13] = mk(1, 1, 0, 32'h0,         32'h48,       0, 32'h0,        32'h0,                7);
        tbl[14] = mk(0, 0, 0, 32'h0,         32'h4C,       1, 32'h4C,       word_at(32'h48),      8);
        tbl[15] = mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,                8);
        tbl[16] = mk(0, 0, 0, 32'h0,         32'h0,        1, 32'h0,        word_at(32'hFFFF_FFFC), 9);

        // Reset with every other input active: rst must win.
        drive(1, 1, 1, 1, 32'h0000_0080);
        step();
        step();
        chk_state("reset", 32'h0, 0, 32'h0, 32'h0, 0);
        chk("reset.read", 32'(imem_read), 32'd0);

        drive(0, 0, 0, 0, 32'h0);
        #1;
        chk("run.read", 32'(imem_read), 32'd1);

        for (int i = 0; i < NV; i++) begin
            drive(0, tbl[i].frz, tbl[i].fls, tbl[i].br, tbl[i].baddr);
            step();
            chk_state($sformatf("v%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].idpc,
                      tbl[i].instr, tbl[i].cnt);
        end

        // Mid-stream reset discards a valid IF/ID and the counter.
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk_state("pre_rst", 32'h4, 1, 32'h4, word_at(32'h0), 10);
        drive(1, 0, 0, 0, 32'h0);
        step();
        chk_state("mid_rst", 32'h0, 0, 32'h0, 32'h0, 0);

        // First post-reset fetch comes from address 0.
        drive(0, 0, 0, 0, 32'h0);
        chk("post_rst.addr", imem_addr, 32'h0);
        step();
        chk_state("post_rst", 32'h4, 1, 32'h4, word_at(32'h0), 1);

        // Flush and branch together: one bubble, pc goes to the target.
        drive(0, 0, 1, 1, 32'h0000_0022);
        step();
        chk_state("fl_br", 32'h20, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk_state("fl_br2", 32'h24, 1, 32'h24, word_at(32'h20), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
